// File: rtl/dcache_refill_ctl_if.sv
// Cache/memory-side signal bundle for the data-cache refill controller.
// slave = the controller itself, master = the cache plus backing memory around it.
interface dcache_refill_ctl_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 512
);
   logic              i_cache_miss;
   logic [ADDR_W-1:0] i_miss_addr;
   logic              i_evict;
   logic [ADDR_W-1:0] i_evict_addr;
   logic [LINE_W-1:0] i_evict_data;
   logic [LINE_W-1:0] o_memory_line;
   logic              o_memory_response;
   logic              o_stall;
   // Memory handshake: o_mem_req is valid, i_mem_ack is ready; a line moves on a
   // cycle where both are high, and req/we/addr/wdata hold steady until then.
   logic              o_mem_req;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [LINE_W-1:0] o_mem_wdata;
   logic              i_mem_ack;
   logic [LINE_W-1:0] i_mem_rdata;
   logic              o_err;
   logic [2:0]        dbg_state;

   modport slave (
      input  i_cache_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
      input  i_mem_ack, i_mem_rdata,
      output o_memory_line, o_memory_response, o_stall,
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_err, dbg_state
   );

   modport master (
      output i_cache_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
      output i_mem_ack, i_mem_rdata,
      input  o_memory_line, o_memory_response, o_stall,
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_err, dbg_state
   );
endinterface

// File: rtl/dcache_refill_ctl.sv
// Data-cache refill controller: optional dirty-victim writeback, line fill,
// one-cycle response pulse to the cache, and a pipeline stall covering it all.
module dcache_refill_ctl #(
   parameter int ADDR_W   = 32,
   parameter int LINE_W   = 512,
   parameter int OFFSET_W = 6,
   parameter int TIMEOUT  = 255
) (
   input logic                clk,
   input logic                rst,
   dcache_refill_ctl_if.slave bus
);
   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_W) - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRBACK = 3'd1,
      FILL   = 3'd2,
      RESP   = 3'd3,
      SETTLE = 3'd4
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] miss_addr_q;
   logic [CNT_W-1:0]  tmo_cnt;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] line_q;
   logic              resp_q;
   logic              err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         miss_addr_q <= '0;
         tmo_cnt     <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         line_q      <= '0;
         resp_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_cache_miss) begin
                  miss_addr_q <= bus.i_miss_addr & ~OFF_MASK;
                  tmo_cnt     <= '0;
                  req_q       <= 1'b1;
                  if (bus.i_evict) begin
                     state   <= WRBACK;
                     we_q    <= 1'b1;
                     addr_q  <= bus.i_evict_addr & ~OFF_MASK;
                     wdata_q <= bus.i_evict_data;
                  end else begin
                     state  <= FILL;
                     we_q   <= 1'b0;
                     addr_q <= bus.i_miss_addr & ~OFF_MASK;
                  end
               end
            end
            WRBACK: begin
               // Ack is tested before the timeout so a last-moment ack still succeeds.
               if (bus.i_mem_ack) begin
                  state   <= FILL;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  wdata_q <= '0;
                  addr_q  <= miss_addr_q;
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  state   <= RESP;
                  resp_q  <= 1'b1;
                  err_q   <= 1'b1;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  wdata_q <= '0;
                  addr_q  <= '0;
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            FILL: begin
               // Entered with req low after a writeback: this is the one-cycle gap.
               if (!req_q) begin
                  req_q <= 1'b1;
               end else if (bus.i_mem_ack) begin
                  state  <= RESP;
                  resp_q <= 1'b1;
                  line_q <= bus.i_mem_rdata;
                  req_q  <= 1'b0;
                  addr_q <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  state   <= RESP;
                  resp_q  <= 1'b1;
                  err_q   <= 1'b1;
                  req_q   <= 1'b0;
                  addr_q  <= '0;
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               resp_q <= 1'b0;
               state  <= SETTLE;
            end
            SETTLE: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               req_q  <= 1'b0;
               resp_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_stall           = bus.i_cache_miss | (state != IDLE);
   assign bus.o_mem_req         = req_q;
   assign bus.o_mem_we          = we_q;
   assign bus.o_mem_addr        = addr_q;
   assign bus.o_mem_wdata       = wdata_q;
   assign bus.o_memory_line     = line_q;
   assign bus.o_memory_response = resp_q;
   assign bus.o_err             = err_q;
   assign bus.dbg_state         = state;
endmodule

// File: tb/tb_dcache_refill_ctl.sv
// Bench for dcache_refill_ctl: a transaction-level model predicts the memory
// transfers, response latency, returned line and error flag of every miss.
module tb_dcache_refill_ctl;
   localparam int AW      = 32;
   localparam int LW      = 512;
   localparam int TIMEOUT = 255;
   localparam int XW      = 1 + AW + LW;

   logic clk;
   logic rst;
   dcache_refill_ctl_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

   dcache_refill_ctl #(.ADDR_W(AW), .LINE_W(LW), .OFFSET_W(6), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;

   // Clock/reset and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] expv);
      cmp_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Memory model: per-request ack delay (-1 = never ack), records accepted transfers
   logic [XW-1:0] exp_q[$];
   logic [XW-1:0] got_q[$];
   int            delay_q[$];
   logic [LW-1:0] fill_data;
   bit            spur_ack;
   int            cyc = 0;
   int            cur_delay;
   int            hi_cnt;
   int            last_wr_ack_cyc;
   bit            in_req, acked, last_was_wr;
   logic [XW-1:0] st_req;

   always @(negedge clk) begin
      logic [XW-1:0] now_req;
      cyc++;
      now_req = {bus.o_mem_we, bus.o_mem_addr, (bus.o_mem_we ? bus.o_mem_wdata : {LW{1'b0}})};
      if (!rst) begin
         in_req = 0; acked = 0; last_was_wr = 0; hi_cnt = 0;
         bus.i_mem_ack = 1'b0;
      end else if (bus.o_mem_req) begin
         if (!in_req) begin
            in_req = 1; acked = 0; hi_cnt = 0;
            cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
            st_req = now_req;
            if (last_was_wr) check("wr_rd_gap", XW'(cyc - last_wr_ack_cyc), XW'(2));
            last_was_wr = 0;
         end else begin
            check("req_stable", now_req, st_req);
         end
         hi_cnt++;
         if (!acked && cur_delay >= 0 && hi_cnt == cur_delay + 1) begin
            acked = 1;
            bus.i_mem_ack = 1'b1;
            bus.i_mem_rdata = st_req[XW-1] ? rand_line() : fill_data;
            got_q.push_back(st_req);
            last_was_wr = st_req[XW-1];
            last_wr_ack_cyc = cyc;
         end else begin
            bus.i_mem_ack = 1'b0;
         end
      end else begin
         if (in_req && !acked) check("tmo_req_cycles", XW'(hi_cnt), XW'(TIMEOUT));
         in_req = 0; acked = 0;
         bus.i_mem_ack = spur_ack;
         bus.i_mem_rdata = rand_line();
      end
   end

   // Reference model state
   logic [LW-1:0] exp_line;
   bit            err_m;

   task automatic do_miss(input logic [AW-1:0] maddr, input bit ev, input logic [AW-1:0] eaddr,
                          input int d_wb, input int d_fill, input bit spur);
      logic [LW-1:0] edata;
      int  lat, lat_m;
      bit  seen, fill_run;
      edata = rand_line();
      fill_data = rand_line();
      exp_q.delete(); got_q.delete(); delay_q.delete();
      lat_m = 2;
      fill_run = !ev || d_wb >= 0;
      if (ev) begin
         delay_q.push_back(d_wb);
         if (d_wb < 0) begin
            err_m = 1; lat_m += TIMEOUT;
         end else begin
            exp_q.push_back({1'b1, eaddr & ~32'h3f, edata});
            lat_m += d_wb + 2;
         end
      end
      if (fill_run) begin
         delay_q.push_back(d_fill);
         if (d_fill < 0) begin
            err_m = 1; lat_m += TIMEOUT;
         end else begin
            exp_q.push_back({1'b0, maddr & ~32'h3f, {LW{1'b0}}});
            exp_line = fill_data;
            lat_m += d_fill + 1;
         end
      end

      @(negedge clk);
      spur_ack = spur;
      bus.i_cache_miss = 1'b1;
      bus.i_miss_addr = maddr;
      bus.i_evict = ev;
      bus.i_evict_addr = eaddr;
      bus.i_evict_data = edata;
      lat = 1;
      seen = 0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         @(negedge clk);
         lat++;
         bus.i_miss_addr = $urandom;
         bus.i_evict = 1'($urandom);
         bus.i_evict_addr = $urandom;
         bus.i_evict_data = rand_line();
         if (bus.o_memory_response) seen = 1;
         else check("stall_held", XW'(bus.o_stall), XW'(1));
      end
      check("resp_seen", XW'(seen), XW'(1));
      check("latency", XW'(lat), XW'(lat_m));
      check("memory_line", XW'(bus.o_memory_line), XW'(exp_line));
      check("err", XW'(bus.o_err), XW'(err_m));
      check("req_low_in_resp", XW'(bus.o_mem_req), XW'(0));

      @(negedge clk);
      check("resp_one_cycle", XW'(bus.o_memory_response), XW'(0));
      check("stall_settle", XW'(bus.o_stall), XW'(1));

      @(negedge clk);
      spur_ack = 1;
      bus.i_cache_miss = 1'b0;
      #1;
      check("stall_release", XW'(bus.o_stall), XW'(0));
      repeat (3) begin
         @(negedge clk);
         #1;
         check("idle_no_req", XW'(bus.o_mem_req), XW'(0));
      end
      spur_ack = 0;
      @(negedge clk);
      check("xfer_count", XW'(got_q.size()), XW'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("xfer%0d", i), got_q[i], exp_q[i]);
      check("err_after", XW'(bus.o_err), XW'(err_m));
   endtask

   initial begin
      rst = 1'b0;
      spur_ack = 0;
      bus.i_cache_miss = 1'b0;
      bus.i_miss_addr = '0;
      bus.i_evict = 1'b0;
      bus.i_evict_addr = '0;
      bus.i_evict_data = '0;
      bus.i_mem_ack = 1'b0;
      bus.i_mem_rdata = '0;
      exp_line = '0;
      err_m = 0;
      repeat (3) @(negedge clk);
      check("rst_req", XW'(bus.o_mem_req), XW'(0));
      check("rst_we", XW'(bus.o_mem_we), XW'(0));
      check("rst_addr", XW'(bus.o_mem_addr), XW'(0));
      check("rst_resp", XW'(bus.o_memory_response), XW'(0));
      check("rst_line", XW'(bus.o_memory_line), XW'(0));
      check("rst_err", XW'(bus.o_err), XW'(0));
      check("rst_stall", XW'(bus.o_stall), XW'(0));
      rst = 1'b1;

      do_miss(32'h0000_1234, 0, 32'h0, 0, 1, 0);
      do_miss(32'h0000_2000, 1, 32'h0000_8040, 0, 0, 0);
      do_miss(32'h0000_5678, 0, 32'h0, 0, 0, 0);
      do_miss(32'h0000_9abc, 0, 32'h0, 0, -1, 0);
      do_miss(32'h0000_4444, 1, 32'h0001_1111, 2, 3, 1);
      do_miss(32'h0000_7f00, 0, 32'h0, 0, 10, 0);
      do_miss(32'h0000_3300, 1, 32'h0002_2200, -1, 0, 0);
      do_miss(32'h0000_3340, 1, 32'h0002_2240, 4, -1, 0);

      // Reset in the middle of a fill that memory never answers
      delay_q.delete(); got_q.delete();
      delay_q.push_back(-1);
      @(negedge clk);
      bus.i_cache_miss = 1'b1;
      bus.i_miss_addr = 32'h0000_6000;
      bus.i_evict = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_req", XW'(bus.o_mem_req), XW'(1));
      bus.i_cache_miss = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_req", XW'(bus.o_mem_req), XW'(0));
      check("arst_addr", XW'(bus.o_mem_addr), XW'(0));
      check("arst_resp", XW'(bus.o_memory_response), XW'(0));
      check("arst_err", XW'(bus.o_err), XW'(0));
      check("arst_stall", XW'(bus.o_stall), XW'(0));
      err_m = 0;
      exp_line = '0;
      repeat (2) @(negedge clk);
      check("arst_no_resp", XW'(bus.o_memory_response), XW'(0));
      rst = 1'b1;
      do_miss(32'h0000_6000, 0, 32'h0, 0, 0, 0);

      for (int n = 0; n < 10; n++)
         do_miss($urandom, 1'($urandom), $urandom, $urandom_range(0, 12),
                 $urandom_range(0, 12), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
